mor1kx_rf_mport: RTL and testbench
==================================

Name: mor1kx_rf_mport

Overview:
Parametrised register file with N read ports and an M-source forwarding network for the cappuccino-class pipeline. It generalises two-port decode/execute bypassing to any read-port count and any forwarding depth. It adds multi-cycle producer tracking, which raises a stall until the forwarded result is valid. It sits between decode (addresses) and execute (operands); writeback writes all RAM copies.

Parameters:
OPTION_OPERAND_WIDTH, 32, data width W
OPTION_RF_ADDR_WIDTH, 5, GPR address width A
OPTION_RF_WORDS, 32, number of GPRs
NUM_RD_PORTS, 2, read ports P (1..4)
NUM_FWD_STAGES, 3, forwarding sources S (1..4); index 0 is youngest, highest priority

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
padv_i  in  1  decode->execute advance; read addresses valid this cycle
pipeline_flush_i  in  1  pipeline flush
rd_adr_i  in  P*A  read addresses, port p at [p*A +: A]
fwd_valid_i  in  S  stage k holds a GPR-writing instruction (sampled at padv_i)
fwd_adr_i  in  S*A  destination address of stage k instruction
res_valid_i  in  S  res_dat_i[k] valid this cycle
res_dat_i  in  S*W  result of the instruction that occupied stage k at the last padv_i
wb_we_i  in  1  writeback enable
wb_adr_i  in  A  writeback address
wb_dat_i  in  W  writeback data
rd_dat_o  out  P*W  execute-stage operands
hazard_stall_o  out  1  some port waits on an unresolved forwarded result
spr_bus_addr_i  in  16  debug GPR read address (low A bits used)
spr_gpr_dat_o  out  W  debug GPR read data

Behaviour:
- Reset: all selects, captured flags and flushing cleared; rd_dat_o=0; hazard_stall_o=0; spr_gpr_dat_o=0. RAM contents are not reset.
- Per-port latch on padv_i & !pipeline_flush_i:
  - RAM read at rd_adr_i[p]; operand valid next cycle (1-cycle latency).
  - sel_p = lowest k with fwd_valid_i[k] & fwd_adr_i[k]==rd_adr_i[p], else NONE.
  - wbhit_p = wb_we_i & wb_adr_i==rd_adr_i[p]; wb_dat_i captured into hold_p. This handles same-cycle write/read; RAM read-before-write is not relied on.
  - captured_p cleared.
- Output per port:
  - sel_p=k & res_valid_i[k]: live res_dat_i[k]; hold_p<=res_dat_i[k]; captured_p<=1.
  - sel_p=k & !res_valid_i[k]: hold_p if captured_p, else X-free hold_p with stall contribution.
  - sel_p=NONE: hold_p if wbhit_p, else RAM output.
- hazard_stall_o = OR over p of (sel_p!=NONE & !captured_p & !res_valid_i[sel_p]). It is combinational from registered state plus res_valid_i. The pipeline must not assert padv_i while it is high; padv_i during stall is an integration error (assertion).
- Writeback while held (no padv) to a latched address with sel_p=NONE: RAM written, operand unchanged. The producer is by construction in a fwd stage at padv.
- Flush: clears all sel_p and captured_p, drops stall that cycle, and sets flushing. padv_i while flushing latches RAM reads and wbhit only, with fwd matches ignored; flushing clears on that padv_i. Flush and padv_i in the same cycle: flush wins, nothing latched.
- Multiple fwd matches: youngest (lowest k) wins. Equal wb and fwd hit: fwd wins.
- Reset mid-stall: stall drops the next cycle.

Optional Feature:
MOR1KX_RF_SPR_PORT_EN
- Defined: an extra RAM copy with rden=1 reads spr_bus_addr_i[A-1:0]; spr_gpr_dat_o is valid 1 cycle later.
- Undefined: no RAM instantiated; spr_gpr_dat_o tied to 0.

Decomposition:
- Package mor1kx_rf_pkg: SEL_NONE encoding, select width $clog2(S+1), helper for port slice offsets.
- Sub-module mor1kx_rf_fwd_port, one per read port: sel/hold/captured/wbhit logic and output mux.
- RAM copies use the existing mor1kx_rf_ram, one per read port plus the optional SPR copy.

Test Plan:
- Write r3=0x11 via wb; then padv with rd_adr[0]=3, no fwd -> rd_dat[0]=0x11 next cycle.
- fwd_valid=3'b011, fwd_adr[0]=fwd_adr[1]=5, rd_adr[1]=5; padv; res_valid=3'b011, res_dat0=0xA, res_dat1=0xB -> port1=0xA, stall=0.
- Stage-1 hit on r7 with res_valid[1]=0 for 3 cycles, then 0x77 -> stall high 3 cycles; port=0x77 thereafter even after res_valid drops.
- padv with wb_we=1, wb_adr=9=rd_adr[0], wb_dat=0x99 -> port0=0x99.
- Flush during stall -> stall 0 next cycle; following padv with stale fwd_adr match -> RAM value used.
- With MOR1KX_RF_SPR_PORT_EN, write r4=0x44, spr_bus_addr=4 -> spr_gpr_dat=0x44 one cycle later; without the macro -> 0.

Source files
------------

// File: rtl/mor1kx_rf_pkg.sv
// rtl/mor1kx_rf_pkg.sv - shared types and helpers for the multi-port register file
package mor1kx_rf_pkg;

  // Where a read port takes its operand from in the execute stage
  typedef enum logic [1:0] {
    SRC_RAM  = 2'd0,
    SRC_HOLD = 2'd1,
    SRC_LIVE = 2'd2
  } op_src_e;

  // Forwarding select width: one code per stage plus the "no forward" code
  function automatic int sel_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  // "No forward" is the all-ones select code, never a valid stage index
  function automatic int sel_none(input int stages);
    return (1 << sel_width(stages)) - 1;
  endfunction

  // Bit offset of element idx in a flattened bus of width-bit elements
  function automatic int slice_off(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mor1kx_rf_fwd_port.sv
// rtl/mor1kx_rf_fwd_port.sv - per-read-port forward select, hold register and operand mux
module mor1kx_rf_fwd_port
  import mor1kx_rf_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int NUM_FWD_STAGES       = 3
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           latch,
  input  logic                                           flush,
  input  logic                                           flushing,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]                rd_adr,
  input  logic [NUM_FWD_STAGES-1:0]                      fwd_valid,
  input  logic [NUM_FWD_STAGES*OPTION_RF_ADDR_WIDTH-1:0] fwd_adr,
  input  logic [NUM_FWD_STAGES-1:0]                      res_valid,
  input  logic [NUM_FWD_STAGES*OPTION_OPERAND_WIDTH-1:0] res_dat,
  input  logic                                           wb_we,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]                wb_adr,
  input  logic [OPTION_OPERAND_WIDTH-1:0]                wb_dat,
  input  logic [OPTION_OPERAND_WIDTH-1:0]                ram_dat,
  output logic [OPTION_OPERAND_WIDTH-1:0]                rd_dat,
  output logic                                           stall
);

  localparam int W     = OPTION_OPERAND_WIDTH;
  localparam int A     = OPTION_RF_ADDR_WIDTH;
  localparam int S     = NUM_FWD_STAGES;
  localparam int SEL_W = sel_width(S);
  localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(sel_none(S));

  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] fwd_match;
  logic [W-1:0]     hold;
  logic             captured;
  logic             wbhit;
  logic             live_valid;
  logic [W-1:0]     live_dat;
  op_src_e          src;

  // Youngest matching forward stage; scanning downwards lets lower indices win
  always_comb begin
    fwd_match = SEL_NONE;
    for (int k = S - 1; k >= 0; k--) begin
      if (fwd_valid[k] && (fwd_adr[k*A +: A] == rd_adr))
        fwd_match = SEL_W'(k);
    end
  end

  // Result bus of the selected stage; stays invalid when nothing is selected
  always_comb begin
    live_valid = 1'b0;
    live_dat   = '0;
    for (int k = 0; k < S; k++) begin
      if (sel == SEL_W'(k)) begin
        live_valid = res_valid[k];
        live_dat   = res_dat[k*W +: W];
      end
    end
  end

  // Select state: latch on advance, clear on flush, capture the forwarded result once seen
  always_ff @(posedge clk) begin
    if (rst) begin
      sel      <= SEL_NONE;
      captured <= 1'b0;
      wbhit    <= 1'b0;
      hold     <= '0;
    end else if (latch) begin
      sel      <= flushing ? SEL_NONE : fwd_match;
      wbhit    <= wb_we && (wb_adr == rd_adr);
      hold     <= wb_dat;
      captured <= 1'b0;
    end else if (flush) begin
      sel      <= SEL_NONE;
      captured <= 1'b0;
    end else if ((sel != SEL_NONE) && live_valid) begin
      hold     <= live_dat;
      captured <= 1'b1;
    end
  end

  // Operand source: live forward beats hold, a writeback hit beats the RAM read
  always_comb begin
    src = SRC_RAM;
    if (sel != SEL_NONE)
      src = live_valid ? SRC_LIVE : SRC_HOLD;
    else if (wbhit)
      src = SRC_HOLD;
  end

  // Operand mux
  always_comb begin
    case (src)
      SRC_LIVE: rd_dat = live_dat;
      SRC_HOLD: rd_dat = hold;
      default:  rd_dat = ram_dat;
    endcase
  end

  assign stall = (sel != SEL_NONE) && !captured && !live_valid;

endmodule

// File: rtl/mor1kx_rf_ram.sv
// rtl/mor1kx_rf_ram.sv - one GPR RAM copy, synchronous read, single write port
module mor1kx_rf_ram #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int OPTION_RF_WORDS      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] rdad,
  input  logic                            rden,
  output logic [OPTION_OPERAND_WIDTH-1:0] rdda,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] wrad,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wrda,
  input  logic                            wren
);

  logic [OPTION_OPERAND_WIDTH-1:0] mem [OPTION_RF_WORDS];

  // Storage write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (wren)
      mem[wrad] <= wrda;
  end

  // Registered read; the output register itself resets so operands start at zero
  always_ff @(posedge clk) begin
    if (rst)
      rdda <= '0;
    else if (rden)
      rdda <= mem[rdad];
  end

endmodule

// File: rtl/mor1kx_rf_mport.sv
// rtl/mor1kx_rf_mport.sv - N-read-port GPR file with forwarding; MOR1KX_RF_SPR_PORT_EN adds the debug read copy
module mor1kx_rf_mport
  import mor1kx_rf_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int OPTION_RF_WORDS      = 32,
  parameter int NUM_RD_PORTS         = 2,
  parameter int NUM_FWD_STAGES       = 3
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           padv_i,
  input  logic                                           pipeline_flush_i,
  input  logic [NUM_RD_PORTS*OPTION_RF_ADDR_WIDTH-1:0]   rd_adr_i,
  input  logic [NUM_FWD_STAGES-1:0]                      fwd_valid_i,
  input  logic [NUM_FWD_STAGES*OPTION_RF_ADDR_WIDTH-1:0] fwd_adr_i,
  input  logic [NUM_FWD_STAGES-1:0]                      res_valid_i,
  input  logic [NUM_FWD_STAGES*OPTION_OPERAND_WIDTH-1:0] res_dat_i,
  input  logic                                           wb_we_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]                wb_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]                wb_dat_i,
  output logic [NUM_RD_PORTS*OPTION_OPERAND_WIDTH-1:0]   rd_dat_o,
  output logic                                           hazard_stall_o,
  input  logic [15:0]                                    spr_bus_addr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0]                spr_gpr_dat_o
);

  localparam int W = OPTION_OPERAND_WIDTH;
  localparam int A = OPTION_RF_ADDR_WIDTH;

  logic                    latch;
  logic                    flushing;
  logic [NUM_RD_PORTS-1:0] port_stall;
  logic                    unused_spr;

  // A flush in the same cycle as an advance wins, so nothing is latched then
  assign latch = padv_i && !pipeline_flush_i;

  // Flushing lasts until the next advance, which must ignore stale forward matches
  always_ff @(posedge clk) begin
    if (rst)
      flushing <= 1'b0;
    else if (pipeline_flush_i)
      flushing <= 1'b1;
    else if (padv_i)
      flushing <= 1'b0;
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    logic [W-1:0] ram_dat;

    mor1kx_rf_ram #(
      .OPTION_OPERAND_WIDTH (W),
      .OPTION_RF_ADDR_WIDTH (A),
      .OPTION_RF_WORDS      (OPTION_RF_WORDS)
    ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .rdad (rd_adr_i[slice_off(p, A) +: A]),
      .rden (latch),
      .rdda (ram_dat),
      .wrad (wb_adr_i),
      .wrda (wb_dat_i),
      .wren (wb_we_i)
    );

    mor1kx_rf_fwd_port #(
      .OPTION_OPERAND_WIDTH (W),
      .OPTION_RF_ADDR_WIDTH (A),
      .NUM_FWD_STAGES       (NUM_FWD_STAGES)
    ) u_port (
      .clk       (clk),
      .rst       (rst),
      .latch     (latch),
      .flush     (pipeline_flush_i),
      .flushing  (flushing),
      .rd_adr    (rd_adr_i[slice_off(p, A) +: A]),
      .fwd_valid (fwd_valid_i),
      .fwd_adr   (fwd_adr_i),
      .res_valid (res_valid_i),
      .res_dat   (res_dat_i),
      .wb_we     (wb_we_i),
      .wb_adr    (wb_adr_i),
      .wb_dat    (wb_dat_i),
      .ram_dat   (ram_dat),
      .rd_dat    (rd_dat_o[slice_off(p, W) +: W]),
      .stall     (port_stall[p])
    );
  end

  // A flush abandons the waiting instruction, so the stall is masked the same cycle
  assign hazard_stall_o = (|port_stall) && !pipeline_flush_i;

  // The pipeline must hold decode while any operand is still pending
  padv_during_stall: assert property (@(posedge clk) disable iff (rst)
    !(padv_i && hazard_stall_o));

  // Upper debug address bits select the SPR group and are not needed here
  assign unused_spr = ^spr_bus_addr_i;

`ifdef MOR1KX_RF_SPR_PORT_EN
  mor1kx_rf_ram #(
    .OPTION_OPERAND_WIDTH (W),
    .OPTION_RF_ADDR_WIDTH (A),
    .OPTION_RF_WORDS      (OPTION_RF_WORDS)
  ) u_spr_ram (
    .clk  (clk),
    .rst  (rst),
    .rdad (spr_bus_addr_i[A-1:0]),
    .rden (1'b1),
    .rdda (spr_gpr_dat_o),
    .wrad (wb_adr_i),
    .wrda (wb_dat_i),
    .wren (wb_we_i)
  );
`else
  assign spr_gpr_dat_o = '0;
`endif

endmodule

// File: tb/tb_mor1kx_rf_mport.sv
// tb/tb_mor1kx_rf_mport.sv - scoreboard bench for the multi-port register file
module tb_mor1kx_rf_mport;

  localparam int W = 32;
  localparam int A = 5;
  localparam int P = 2;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           padv_i;
  logic           pipeline_flush_i;
  logic [P*A-1:0] rd_adr_i;
  logic [S-1:0]   fwd_valid_i;
  logic [S*A-1:0] fwd_adr_i;
  logic [S-1:0]   res_valid_i;
  logic [S*W-1:0] res_dat_i;
  logic           wb_we_i;
  logic [A-1:0]   wb_adr_i;
  logic [W-1:0]   wb_dat_i;
  logic [P*W-1:0] rd_dat_o;
  logic           hazard_stall_o;
  logic [15:0]    spr_bus_addr_i;
  logic [W-1:0]   spr_gpr_dat_o;

  mor1kx_rf_mport #(
    .OPTION_OPERAND_WIDTH (W),
    .OPTION_RF_ADDR_WIDTH (A),
    .OPTION_RF_WORDS      (32),
    .NUM_RD_PORTS         (P),
    .NUM_FWD_STAGES       (S)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .padv_i           (padv_i),
    .pipeline_flush_i (pipeline_flush_i),
    .rd_adr_i         (rd_adr_i),
    .fwd_valid_i      (fwd_valid_i),
    .fwd_adr_i        (fwd_adr_i),
    .res_valid_i      (res_valid_i),
    .res_dat_i        (res_dat_i),
    .wb_we_i          (wb_we_i),
    .wb_adr_i         (wb_adr_i),
    .wb_dat_i         (wb_dat_i),
    .rd_dat_o         (rd_dat_o),
    .hazard_stall_o   (hazard_stall_o),
    .spr_bus_addr_i   (spr_bus_addr_i),
    .spr_gpr_dat_o    (spr_gpr_dat_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    int           port;
    logic [W-1:0] dat;
  } exp_t;

  exp_t sb_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input int adr);
    rd_adr_i[p*A +: A] = A'(adr);
  endtask

  task automatic set_fwd(input int k, input int adr);
    fwd_adr_i[k*A +: A] = A'(adr);
  endtask

  task automatic set_res(input int k, input logic [W-1:0] dat);
    res_dat_i[k*W +: W] = dat;
  endtask

  task automatic wb_write(input int adr, input logic [W-1:0] dat);
    wb_we_i  = 1'b1;
    wb_adr_i = A'(adr);
    wb_dat_i = dat;
    tick();
    wb_we_i  = 1'b0;
  endtask

  task automatic expect_op(input string name, input int port, input logic [W-1:0] dat);
    exp_t e;
    e.name = name;
    e.port = port;
    e.dat  = dat;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    padv_i = 1'b0; pipeline_flush_i = 1'b0; rd_adr_i = '0;
    fwd_valid_i = '0; fwd_adr_i = '0; res_valid_i = '0; res_dat_i = '0;
    wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0; spr_bus_addr_i = '0;
    tick(); tick();
    chk_cnt++;
    if (rd_dat_o !== '0) $display("FAIL reset_rd_dat: got %h want 0", rd_dat_o); else pass_cnt++;
    chk_cnt++;
    if (hazard_stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", hazard_stall_o); else pass_cnt++;
    chk_cnt++;
    if (spr_gpr_dat_o !== '0) $display("FAIL reset_spr: got %h want 0", spr_gpr_dat_o); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ram_read();
    exp_t e;
    wb_write(3, 32'h11);
    wb_write(8, 32'h88);
    set_rd(0, 3); set_rd(1, 8);
    padv_i = 1'b1;
    expect_op("ram_p0", 0, 32'h11);
    expect_op("ram_p1", 1, 32'h88);
    tick();
    padv_i = 1'b0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_cnt++;
      if (rd_dat_o[e.port*W +: W] !== e.dat)
        $display("FAIL %s: port%0d got %h want %h", e.name, e.port, rd_dat_o[e.port*W +: W], e.dat);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 4; i++) wb_write(10 + i, 32'h1000 + 32'(i) * 32'h111);
    for (int i = 0; i < 4; i++) begin
      set_rd(0, 10 + i); set_rd(1, 13 - i);
      padv_i = 1'b1;
      expect_op("b2b_p0", 0, 32'h1000 + 32'(i) * 32'h111);
      expect_op("b2b_p1", 1, 32'h1000 + 32'(3 - i) * 32'h111);
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk_cnt++;
        if (rd_dat_o[e.port*W +: W] !== e.dat)
          $display("FAIL %s: port%0d got %h want %h", e.name, e.port, rd_dat_o[e.port*W +: W], e.dat);
        else pass_cnt++;
      end
    end
    padv_i = 1'b0;
  endtask

  task automatic test_fwd_priority();
    exp_t e;
    fwd_valid_i = 3'b011; set_fwd(0, 5); set_fwd(1, 5); set_fwd(2, 0);
    set_rd(0, 3); set_rd(1, 5);
    wb_we_i = 1'b1; wb_adr_i = 5'd5; wb_dat_i = 32'h55;
    padv_i = 1'b1;
    tick();
    padv_i = 1'b0; wb_we_i = 1'b0; fwd_valid_i = '0;
    chk_cnt++;
    if (hazard_stall_o !== 1'b1) $display("FAIL fwd_pending_stall: got %b want 1", hazard_stall_o); else pass_cnt++;
    res_valid_i = 3'b011; set_res(0, 32'hA); set_res(1, 32'hB);
    expect_op("fwd_youngest", 1, 32'hA);
    expect_op("fwd_other_ram", 0, 32'h11);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_cnt++;
      if (rd_dat_o[e.port*W +: W] !== e.dat)
        $display("FAIL %s: port%0d got %h want %h", e.name, e.port, rd_dat_o[e.port*W +: W], e.dat);
      else pass_cnt++;
    end
    chk_cnt++;
    if (hazard_stall_o !== 1'b0) $display("FAIL fwd_live_stall: got %b want 0", hazard_stall_o); else pass_cnt++;
    tick();
    res_valid_i = '0; set_res(0, 32'hDEAD);
    expect_op("fwd_captured", 1, 32'hA);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_cnt++;
      if (rd_dat_o[e.port*W +: W] !== e.dat)
        $display("FAIL %s: port%0d got %h want %h", e.name, e.port, rd_dat_o[e.port*W +: W], e.dat);
      else pass_cnt++;
    end
    chk_cnt++;
    if (hazard_stall_o !== 1'b0) $display("FAIL fwd_captured_stall: got %b want 0", hazard_stall_o); else pass_cnt++;
  endtask

  task automatic test_multicycle();
    exp_t e;
    fwd_valid_i = 3'b010; set_fwd(1, 7);
    set_rd(0, 7); set_rd(1, 3);
    padv_i = 1'b1;
    tick();
    padv_i = 1'b0; fwd_valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      chk_cnt++;
      if (hazard_stall_o !== 1'b1) $display("FAIL mc_stall_%0d: got %b want 1", i, hazard_stall_o); else pass_cnt++;
      tick();
    end
    res_valid_i = 3'b010; set_res(1, 32'h77);
    expect_op("mc_live", 0, 32'h77);
    expect_op("mc_other", 1, 32'h11);
    #1;
    for (int i = 0; i < 3; i++) begin
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk_cnt++;
        if (rd_dat_o[e.port*W +: W] !== e.dat)
          $display("FAIL %s: port%0d got %h want %h", e.name, e.port, rd_dat_o[e.port*W +: W], e.dat);
        else pass_cnt++;
      end
      chk_cnt++;
      if (hazard_stall_o !== 1'b0) $display("FAIL mc_resolved_stall_%0d: got %b want 0", i, hazard_stall_o); else pass_cnt++;
      tick();
      res_valid_i = '0; set_res(1, 32'hBAD0 + 32'(i));
      expect_op("mc_held", 0, 32'h77);
      #1;
    end
    sb_q.delete();
  endtask

  task automatic test_wb_bypass();
    exp_t e;
    wb_we_i = 1'b1; wb_adr_i = 5'd9; wb_dat_i = 32'h99;
    set_rd(0, 9);
    padv_i = 1'b1;
    expect_op("wb_bypass", 0, 32'h99);
    tick();
    padv_i = 1'b0; wb_we_i = 1'b0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_cnt++;
      if (rd_dat_o[e.port*W +: W] !== e.dat)
        $display("FAIL %s: port%0d got %h want %h", e.name, e.port, rd_dat_o[e.port*W +: W], e.dat);
      else pass_cnt++;
    end
    wb_write(9, 32'h100);
    expect_op("wb_while_held", 0, 32'h99);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_cnt++;
      if (rd_dat_o[e.port*W +: W] !== e.dat)
        $display("FAIL %s: port%0d got %h want %h", e.name, e.port, rd_dat_o[e.port*W +: W], e.dat);
      else pass_cnt++;
    end
    padv_i = 1'b1;
    expect_op("wb_reread", 0, 32'h100);
    tick();
    padv_i = 1'b0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_cnt++;
      if (rd_dat_o[e.port*W +: W] !== e.dat)
        $display("FAIL %s: port%0d got %h want %h", e.name, e.port, rd_dat_o[e.port*W +: W], e.dat);
      else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    exp_t e;
    wb_write(12, 32'hC0);
    fwd_valid_i = 3'b001; set_fwd(0, 12);
    set_rd(0, 12); set_rd(1, 3);
    padv_i = 1'b1;
    tick();
    padv_i = 1'b0; fwd_valid_i = '0;
    chk_cnt++;
    if (hazard_stall_o !== 1'b1) $display("FAIL flush_pre_stall: got %b want 1", hazard_stall_o); else pass_cnt++;
    pipeline_flush_i = 1'b1;
    #1;
    chk_cnt++;
    if (hazard_stall_o !== 1'b0) $display("FAIL flush_same_cycle_stall: got %b want 0", hazard_stall_o); else pass_cnt++;
    tick();
    pipeline_flush_i = 1'b0;
    chk_cnt++;
    if (hazard_stall_o !== 1'b0) $display("FAIL flush_next_stall: got %b want 0", hazard_stall_o); else pass_cnt++;
    // Stale forward match right after flush must be ignored
    fwd_valid_i = 3'b001; set_fwd(0, 12);
    padv_i = 1'b1;
    expect_op("flush_stale_ram", 0, 32'hC0);
    tick();
    padv_i = 1'b0; fwd_valid_i = '0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_cnt++;
      if (rd_dat_o[e.port*W +: W] !== e.dat)
        $display("FAIL %s: port%0d got %h want %h", e.name, e.port, rd_dat_o[e.port*W +: W], e.dat);
      else pass_cnt++;
    end
    chk_cnt++;
    if (hazard_stall_o !== 1'b0) $display("FAIL flush_stale_stall: got %b want 0", hazard_stall_o); else pass_cnt++;
    // Flush together with advance: nothing latched
    set_rd(0, 3);
    padv_i = 1'b1; pipeline_flush_i = 1'b1;
    expect_op("flush_beats_padv", 0, 32'hC0);
    tick();
    padv_i = 1'b0; pipeline_flush_i = 1'b0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_cnt++;
      if (rd_dat_o[e.port*W +: W] !== e.dat)
        $display("FAIL %s: port%0d got %h want %h", e.name, e.port, rd_dat_o[e.port*W +: W], e.dat);
      else pass_cnt++;
    end
    // First advance after that flush still ignores forwards, the next one does not
    fwd_valid_i = 3'b001; set_fwd(0, 3);
    padv_i = 1'b1;
    expect_op("flush_ignore_fwd", 0, 32'h11);
    tick();
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_cnt++;
      if (rd_dat_o[e.port*W +: W] !== e.dat)
        $display("FAIL %s: port%0d got %h want %h", e.name, e.port, rd_dat_o[e.port*W +: W], e.dat);
      else pass_cnt++;
    end
    chk_cnt++;
    if (hazard_stall_o !== 1'b0) $display("FAIL flush_ignore_stall: got %b want 0", hazard_stall_o); else pass_cnt++;
    tick();
    padv_i = 1'b0; fwd_valid_i = '0;
    chk_cnt++;
    if (hazard_stall_o !== 1'b1) $display("FAIL post_flush_fwd_stall: got %b want 1", hazard_stall_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cnt++;
    if (hazard_stall_o !== 1'b0) $display("FAIL rst_mid_stall: got %b want 0", hazard_stall_o); else pass_cnt++;
    chk_cnt++;
    if (rd_dat_o !== '0) $display("FAIL rst_mid_rd_dat: got %h want 0", rd_dat_o); else pass_cnt++;
  endtask

  task automatic test_spr();
    logic [W-1:0] exp_spr;
`ifdef MOR1KX_RF_SPR_PORT_EN
    exp_spr = 32'h44;
`else
    exp_spr = 32'h0;
`endif
    wb_write(4, 32'h44);
    spr_bus_addr_i = 16'h0004;
    tick();
    chk_cnt++;
    if (spr_gpr_dat_o !== exp_spr) $display("FAIL spr_read: got %h want %h", spr_gpr_dat_o, exp_spr); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ram_read();
    test_back_to_back();
    test_fwd_priority();
    test_multicycle();
    test_wb_bypass();
    test_flush();
    test_reset_mid_stall();
    test_spr();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
